// File: rtl/sr_input_conditioner_pkg.sv
// Shared definitions for the SR input conditioner: control FSM encoding and
// the default debounce length used by the block and its bench.
package sr_input_conditioner_pkg;

   localparam int DEBOUNCE_CYCLES_DEF = 4;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_CONFLICT = 1'b1
   } ctrl_state_t;

endpackage : sr_input_conditioner_pkg

// File: rtl/sr_input_conditioner_debounce_sync.sv
// One input channel: two-flop synchronizer, consecutive-sample debounce counter,
// debounced level and a one-cycle flag marking each 0->1 change of that level.
module debounce_sync
   import sr_input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   output logic o_stable,
   output logic o_stable_nxt,
   output logic o_rise
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic [CW-1:0] r_cnt;
   logic          r_stable;
   logic          r_rise;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_stable_nxt;

   // Any sample matching the debounced level restarts the count.
   always_comb begin
      w_cnt_nxt    = r_cnt;
      w_stable_nxt = r_stable;
      if (r_sync2 == r_stable) begin
         w_cnt_nxt = '0;
      end else if (r_cnt == CNT_MAX) begin
         w_cnt_nxt    = '0;
         w_stable_nxt = ~r_stable;
      end else begin
         w_cnt_nxt = r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_cnt    <= '0;
         r_stable <= 1'b0;
         r_rise   <= 1'b0;
      end else begin
         r_sync1  <= i_raw;
         r_sync2  <= r_sync1;
         r_cnt    <= w_cnt_nxt;
         r_stable <= w_stable_nxt;
         r_rise   <= w_stable_nxt & ~r_stable;
      end
   end

   assign o_stable     = r_stable;
   assign o_stable_nxt = w_stable_nxt;
   assign o_rise       = r_rise;

endmodule : debounce_sync

// File: rtl/sr_input_conditioner.sv
// Turns two bouncing pushbutton levels into clean one-cycle set/reset pulses
// for a downstream SR latch, suppressing both while the two requests overlap.
module sr_input_conditioner
   import sr_input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic set_in,
   input  logic reset_in,
   output logic s,
   output logic r,
   output logic conflict
);

   ctrl_state_t r_state;
   ctrl_state_t w_state_nxt;
   logic        r_s;
   logic        r_r;
   logic        w_s_nxt;
   logic        w_r_nxt;
   logic        w_set_stable;
   logic        w_set_stable_nxt;
   logic        w_set_rise;
   logic        w_rst_stable;
   logic        w_rst_stable_nxt;
   logic        w_rst_rise;

   debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_ch (
      .clk          (clk),
      .rst          (rst),
      .i_raw        (set_in),
      .o_stable     (w_set_stable),
      .o_stable_nxt (w_set_stable_nxt),
      .o_rise       (w_set_rise)
   );

   debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst_ch (
      .clk          (clk),
      .rst          (rst),
      .i_raw        (reset_in),
      .o_stable     (w_rst_stable),
      .o_stable_nxt (w_rst_stable_nxt),
      .o_rise       (w_rst_rise)
   );

   // State follows the post-edge debounced levels so CONFLICT starts on the
   // same edge the second level goes high; a pending rise is dropped then.
   always_comb begin
      w_state_nxt = r_state;
      w_s_nxt     = 1'b0;
      w_r_nxt     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_set_stable_nxt && w_rst_stable_nxt) begin
               w_state_nxt = ST_CONFLICT;
            end else begin
               w_s_nxt = w_set_rise & ~w_rst_stable;
               w_r_nxt = w_rst_rise & ~w_set_stable;
            end
         end
         ST_CONFLICT: begin
            if (!w_set_stable_nxt || !w_rst_stable_nxt) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_s     <= 1'b0;
         r_r     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_s     <= w_s_nxt;
         r_r     <= w_r_nxt;
      end
   end

   assign s        = r_s;
   assign r        = r_r;
   assign conflict = (r_state == ST_CONFLICT);

endmodule : sr_input_conditioner

// File: tb/tb_sr_input_conditioner.sv
// Bench for sr_input_conditioner: scenario driver queues expected pulses
// (kind + edge number); a negedge monitor pops and checks every pulse seen.
module tb_sr_input_conditioner;
   import sr_input_conditioner_pkg::*;

   localparam int LAT    = DEBOUNCE_CYCLES_DEF + 2;
   localparam int SETTLE = 2 * DEBOUNCE_CYCLES_DEF + 8;
   localparam logic [1:0] K_S = 2'b01;
   localparam logic [1:0] K_R = 2'b10;

   logic clk      = 1'b0;
   logic rst      = 1'b1;
   logic set_in   = 1'b0;
   logic reset_in = 1'b0;
   logic s;
   logic r;
   logic conflict;

   int unsigned cyc = 0;
   int          checks = 0;
   int          failures = 0;
   logic [17:0] exp_q[$];

   sr_input_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES_DEF)) dut (
      .clk      (clk),
      .rst      (rst),
      .set_in   (set_in),
      .reset_in (reset_in),
      .s        (s),
      .r        (r),
      .conflict (conflict)
   );

   // ---------------- clock / edge counter ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- checking ----------------
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   task automatic push_pulse(input logic [1:0] kind, input int unsigned e_n);
      exp_q.push_back({kind, e_n[15:0]});
   endtask

   // ---------------- driver helpers ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_to(input int unsigned e_n);
      while (cyc < e_n) @(negedge clk);
   endtask

   task automatic expect_conflict(input string tag, input int n, input logic val);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_val(tag, 32'(conflict), 32'(val));
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [17:0] e;
      check_val("s_r_mutex", 32'(s & r), 32'd0);
      if (s || r) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_pulse", 32'({r, s}), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check_val("pulse_kind", 32'({r, s}), 32'(e[17:16]));
            check_val("pulse_edge", cyc, {16'd0, e[15:0]});
         end
      end
   end

   // ---------------- scenarios ----------------
   initial begin
      int unsigned k;
      int hold;

      // reset state
      idle(3);
      check_val("rst_s", 32'(s), 32'd0);
      check_val("rst_r", 32'(r), 32'd0);
      check_val("rst_conflict", 32'(conflict), 32'd0);
      rst = 1'b0;
      idle(4);

      // clean set press
      set_in = 1'b1;
      k = cyc + 1;
      push_pulse(K_S, k + LAT);
      wait_to(k + LAT - 1);
      check_val("clean_early_s", 32'(s), 32'd0);
      hold = int'($urandom_range(15, 25));
      expect_conflict("clean_conflict", hold, 1'b0);
      set_in = 1'b0;
      idle(SETTLE);
      check_val("clean_q_empty", 32'(exp_q.size()), 32'd0);

      // bouncing reset press
      reset_in = 1'b1; idle(1);
      reset_in = 1'b0; idle(1);
      reset_in = 1'b1; idle(1);
      reset_in = 1'b0; idle(1);
      reset_in = 1'b1;
      k = cyc + 1;
      push_pulse(K_R, k + LAT);
      expect_conflict("bounce_conflict", 20, 1'b0);
      reset_in = 1'b0;
      idle(SETTLE);
      check_val("bounce_q_empty", 32'(exp_q.size()), 32'd0);

      // short glitch on set
      set_in = 1'b1;
      idle(DEBOUNCE_CYCLES_DEF - 1);
      set_in = 1'b0;
      expect_conflict("glitch_conflict", SETTLE, 1'b0);
      check_val("glitch_q_empty", 32'(exp_q.size()), 32'd0);

      // conflict: set held, then reset pressed over it
      set_in = 1'b1;
      k = cyc + 1;
      push_pulse(K_S, k + LAT);
      idle(LAT + 4);
      reset_in = 1'b1;
      k = cyc + 1;
      wait_to(k + DEBOUNCE_CYCLES_DEF);
      check_val("cfl_before", 32'(conflict), 32'd0);
      expect_conflict("cfl_enter", 1, 1'b1);
      expect_conflict("cfl_hold", 10, 1'b1);
      set_in = 1'b0;
      k = cyc + 1;
      wait_to(k + DEBOUNCE_CYCLES_DEF);
      check_val("cfl_still", 32'(conflict), 32'd1);
      expect_conflict("cfl_exit", 1, 1'b0);
      expect_conflict("cfl_after", 12, 1'b0);
      reset_in = 1'b0;
      idle(SETTLE);
      reset_in = 1'b1;
      k = cyc + 1;
      push_pulse(K_R, k + LAT);
      idle(LAT + 6);
      reset_in = 1'b0;
      idle(SETTLE);
      check_val("cfl_q_empty", 32'(exp_q.size()), 32'd0);

      // simultaneous press
      set_in   = 1'b1;
      reset_in = 1'b1;
      k = cyc + 1;
      wait_to(k + DEBOUNCE_CYCLES_DEF);
      check_val("sim_before", 32'(conflict), 32'd0);
      expect_conflict("sim_conflict", 12, 1'b1);
      set_in   = 1'b0;
      reset_in = 1'b0;
      idle(SETTLE);
      check_val("sim_released", 32'(conflict), 32'd0);
      check_val("sim_q_empty", 32'(exp_q.size()), 32'd0);

      // reset asserted mid-count, input held through release
      set_in = 1'b1;
      idle(2);
      rst = 1'b1;
      idle(1);
      check_val("midrst_s", 32'(s), 32'd0);
      check_val("midrst_conflict", 32'(conflict), 32'd0);
      idle(2);
      rst = 1'b0;
      k = cyc + 1;
      push_pulse(K_S, k + LAT);
      wait_to(k + LAT - 1);
      check_val("midrst_early_s", 32'(s), 32'd0);
      idle(12);
      set_in = 1'b0;
      idle(SETTLE);
      check_val("midrst_q_empty", 32'(exp_q.size()), 32'd0);

      idle(4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule : tb_sr_input_conditioner

// File: doc/sr_input_conditioner.md
SR_INPUT_CONDITIONER -- requirements
Module: sr_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive stable synchronized samples needed to accept a level change (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 set_in  input  1  raw asynchronous set request (pushbutton level), may bounce.
REQ-005 reset_in  input  1  raw asynchronous reset request (pushbutton level), may bounce.
REQ-006 s  output  1  registered one-cycle set pulse; drives a downstream SR latch s input.
REQ-007 r  output  1  registered one-cycle reset pulse; drives a downstream SR latch r input.
REQ-008 conflict  output  1  registered; high while both debounced requests are high.

Function
REQ-009 Each raw input SHALL pass through a two-flop synchronizer before any other use.
REQ-010 Each channel SHALL hold a debounced level "stable" and a counter of width ceil(log2(DEBOUNCE_CYCLES)).
REQ-011 When the synchronized value equals stable, the counter SHALL clear to 0.
REQ-012 When it differs and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment.
REQ-013 When it differs and counter == DEBOUNCE_CYCLES-1, stable SHALL toggle and the counter SHALL clear.
REQ-014 A single differing-to-equal sample (bounce) SHALL restart the count from 0.
REQ-015 Only a 0->1 transition of stable SHALL create a request; 1->0 transitions never create pulses.
REQ-016 Control FSM states: IDLE, CONFLICT; reset state IDLE.
REQ-017 IDLE -> CONFLICT when both stable levels are 1 after the edge; conflict SHALL be 1 exactly while in CONFLICT.
REQ-018 CONFLICT -> IDLE when either stable level returns to 0; the remaining high channel SHALL NOT produce a pulse on exit.
REQ-019 In IDLE, a set request with reset's stable level 0 SHALL drive s=1 for exactly one cycle on the next edge; symmetrically for r.
REQ-020 A request while the other channel's stable level is 1, or simultaneous set and reset requests in the same cycle, SHALL be dropped and the FSM enters CONFLICT.
REQ-021 s and r SHALL never both be 1 in any cycle; both SHALL be 0 in CONFLICT.
REQ-022 Latency: with edge k the first edge sampling a clean high input, the pulse SHALL be high between edges k+DEBOUNCE_CYCLES+2 and k+DEBOUNCE_CYCLES+3.
REQ-023 A held input produces one pulse only; the next pulse requires a debounced release then a new debounced press.

Reset
REQ-024 While rst=1: s=0, r=0, conflict=0, FSM=IDLE, synchronizers, stable levels and counters all 0, independent of clk.
REQ-025 Reset asserted mid-count SHALL discard the partial count; an input held high through reset release SHALL yield one pulse after full REQ-022 latency measured from the first post-release edge.

Structure
REQ-026 FSM state encodings and the default DEBOUNCE_CYCLES constant SHALL live in a shared seq_logic header included by this block and its bench.
REQ-027 One sub-module, debounce_sync (synchronizer + counter + stable + rise flag), SHALL be instantiated twice, once per channel.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Clean press: set_in 0->1 held 20 cycles at edge k -> s=1 only between edges k+6 and k+7; r=0, conflict=0 throughout.
REQ-029 Bounce: reset_in toggles 1,0,1,0 on successive edges then holds 1 -> r pulses once, 6 edges after the final 0->1 sample; no earlier pulse.
REQ-030 Glitch: set_in high for 3 edges then low -> s, r, conflict remain 0.
REQ-031 Conflict: set pressed, pulse seen, reset pressed while set held -> r never pulses, conflict=1 from stable-both; release set -> conflict=0, no r pulse; release and re-press reset -> one r pulse.
REQ-032 Simultaneous: set_in and reset_in rise on same edge k -> s=r=0 always, conflict=1 from edge k+5.
REQ-033 Reset mid-count: rst asserted 2 cycles after set_in rise, released with set_in held -> s=0 during and immediately after reset, then single pulse 6 edges after release; checker asserts !(s&&r) every cycle.
